// File: rtl/msu_audio_sector_feeder.sv
// msu_audio_sector_feeder
//   Responder side of the MSU-1 audio sector interface. A request (or seek)
//   accepted in idle fetches one 1024-byte sector from backing memory as 512
//   sequential 16-bit reads and replays each word on the audio_data_wr strobe,
//   holding ack/download high for the whole transfer. Abort cancels a transfer;
//   a read still in flight is drained so its late response is discarded.
//
// Ports
//   clk_i            system clock
//   reset_i          synchronous, active-high reset
//   track_base_i     byte address of the PCM file, sampled on request accept
//   abort_i          level, cancels the transfer in progress
//   audio_req_i      level, fetch the next sector
//   audio_seek_i     level, fetch a sector out of sequence (same as req)
//   audio_sector_i   sector index, sampled on request accept
//   audio_ack_o      high for the whole transfer of one sector
//   audio_download_o high for the whole transfer
//   audio_data_wr_o  one-cycle strobe per word
//   audio_data_o     word data, valid with audio_data_wr_o
//   mem_rd_o         one-cycle read strobe
//   mem_addr_o       read byte address, valid with mem_rd_o
//   mem_ready_i      one-cycle strobe, mem_dout_i valid
//   mem_dout_i       read data
module msu_audio_sector_feeder (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] track_base_i,
    input  logic        abort_i,
    input  logic        audio_req_i,
    input  logic        audio_seek_i,
    input  logic [21:0] audio_sector_i,
    output logic        audio_ack_o,
    output logic        audio_download_o,
    output logic        audio_data_wr_o,
    output logic [15:0] audio_data_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [15:0] mem_dout_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone,
        StDrain
    } state_e;

    state_e      state_q;
    logic [8:0]  wcnt_q;
    logic        ack_q;
    logic        download_q;
    logic        data_wr_q;
    logic [15:0] data_q;
    logic        mem_rd_q;
    logic [31:0] addr_q;
    logic [31:0] start_addr;

    // Sector start; 32-bit modulo, so a track near the top of memory wraps.
    assign start_addr = track_base_i + {audio_sector_i, 10'b0};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            wcnt_q     <= 9'd0;
            ack_q      <= 1'b0;
            download_q <= 1'b0;
            data_wr_q  <= 1'b0;
            data_q     <= 16'h0000;
            mem_rd_q   <= 1'b0;
            addr_q     <= 32'h0000_0000;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            data_wr_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            if (abort_i && (state_q != StIdle) && (state_q != StDrain)) begin
                ack_q      <= 1'b0;
                download_q <= 1'b0;
                // A read is in flight if it is being issued now, or we are
                // waiting and its response has not arrived this cycle.
                if ((state_q == StRead) || ((state_q == StWait) && !mem_ready_i)) begin
                    state_q <= StDrain;
                end else begin
                    state_q <= StIdle;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if ((audio_req_i || audio_seek_i) && !abort_i) begin
                            wcnt_q     <= 9'd0;
                            ack_q      <= 1'b1;
                            download_q <= 1'b1;
                            addr_q     <= start_addr;
                            mem_rd_q   <= 1'b1;
                            state_q    <= StRead;
                        end
                    end
                    StRead: begin
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (mem_ready_i) begin
                            data_q    <= mem_dout_i;
                            data_wr_q <= 1'b1;
                            state_q   <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (wcnt_q == 9'd511) begin
                            ack_q      <= 1'b0;
                            download_q <= 1'b0;
                            state_q    <= StDone;
                        end else begin
                            wcnt_q   <= wcnt_q + 9'd1;
                            addr_q   <= addr_q + 32'd2;
                            mem_rd_q <= 1'b1;
                            state_q  <= StRead;
                        end
                    end
                    StDone: begin
                        // Extra idle-side cycle keeps download low for two cycles.
                        state_q <= StIdle;
                    end
                    StDrain: begin
                        if (mem_ready_i) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign audio_ack_o      = ack_q;
    assign audio_download_o = download_q;
    assign audio_data_wr_o  = data_wr_q;
    assign audio_data_o     = data_q;
    assign mem_rd_o         = mem_rd_q;
    assign mem_addr_o       = addr_q;

endmodule

// File: tb/tb_msu_audio_sector_feeder.sv
// Directed bench for msu_audio_sector_feeder with a behavioural memory that
// answers each read with word = address[16:1] after a fixed or random latency.
module tb_msu_audio_sector_feeder;

    logic        clk;
    logic        reset;
    logic [31:0] track_base;
    logic        abort;
    logic        audio_req;
    logic        audio_seek;
    logic [21:0] audio_sector;
    logic        audio_ack;
    logic        audio_download;
    logic        audio_data_wr;
    logic [15:0] audio_data;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_dout;

    int tests = 0;
    int fails = 0;

    // memory model state
    bit          lat_rand  = 1'b0;
    int          lat_fixed = 1;
    bit          pending   = 1'b0;
    int          cd        = 0;
    logic [31:0] pend_addr = 32'h0;
    int          rdy_cnt   = 0;
    int          multi_rd  = 0;

    // monitor state
    logic [31:0] exp_start  = 32'h0;
    int          wr_cnt     = 0;
    int          rd_cnt     = 0;
    int          data_err   = 0;
    int          addr_err   = 0;
    logic [31:0] first_addr = 32'h0;
    logic [31:0] last_addr  = 32'h0;

    msu_audio_sector_feeder dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .track_base_i     (track_base),
        .abort_i          (abort),
        .audio_req_i      (audio_req),
        .audio_seek_i     (audio_seek),
        .audio_sector_i   (audio_sector),
        .audio_ack_o      (audio_ack),
        .audio_download_o (audio_download),
        .audio_data_wr_o  (audio_data_wr),
        .audio_data_o     (audio_data),
        .mem_rd_o         (mem_rd),
        .mem_addr_o       (mem_addr),
        .mem_ready_i      (mem_ready),
        .mem_dout_i       (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: read seen in cycle R -> mem_ready in cycle R+L.
    initial begin
        mem_ready = 1'b0;
        mem_dout  = 16'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (pending) begin
                cd = cd - 1;
                if (cd <= 0) begin
                    mem_ready = 1'b1;
                    mem_dout  = pend_addr[16:1];
                    pending   = 1'b0;
                    rdy_cnt   = rdy_cnt + 1;
                end
            end
            if (mem_rd === 1'b1) begin
                if (pending) multi_rd = multi_rd + 1;
                pending   = 1'b1;
                pend_addr = mem_addr;
                cd        = lat_rand ? 1 + int'($urandom_range(0, 7)) : lat_fixed;
            end
        end
    end

    // Monitor: read address sequence and written data order.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                e = exp_start + 32'(rd_cnt) * 32'd2;
                if (rd_cnt == 0) first_addr = mem_addr;
                last_addr = mem_addr;
                if (mem_addr !== e) addr_err = addr_err + 1;
                rd_cnt = rd_cnt + 1;
            end
            if (audio_data_wr === 1'b1) begin
                e = exp_start + 32'(wr_cnt) * 32'd2;
                if (audio_data !== e[16:1]) data_err = data_err + 1;
                wr_cnt = wr_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon(input logic [31:0] start);
        exp_start = start;
        wr_cnt    = 0;
        rd_cnt    = 0;
        data_err  = 0;
        addr_err  = 0;
    endtask

    // Wait for ack with a bound; an expired bound counts as a failure.
    task automatic wait_ack(input string name, input int bound);
        int n;
        n = 0;
        while (audio_ack !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        tests++;
        if (audio_ack !== 1'b1) begin
            fails++;
            $display("FAIL %s: ack timeout, got %b want 1", name, audio_ack);
        end
    endtask

    task automatic wait_words(input string name, input int want, input int bound);
        int n;
        n = 0;
        while (wr_cnt < want && n < bound) begin
            tick();
            n++;
        end
        tests++;
        if (wr_cnt < want) begin
            fails++;
            $display("FAIL %s: word timeout, got %0d want %0d", name, wr_cnt, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; abort = 1'b0; audio_req = 1'b0; audio_seek = 1'b0;
        track_base = 32'h0; audio_sector = 22'h0;
        repeat (3) tick();
        tests++; if (audio_ack !== 1'b0) begin fails++;
            $display("FAIL reset_ack: got %b want 0", audio_ack); end
        tests++; if (audio_download !== 1'b0) begin fails++;
            $display("FAIL reset_download: got %b want 0", audio_download); end
        tests++; if (audio_data_wr !== 1'b0) begin fails++;
            $display("FAIL reset_data_wr: got %b want 0", audio_data_wr); end
        tests++; if (audio_data !== 16'h0) begin fails++;
            $display("FAIL reset_data: got %h want 0000", audio_data); end
        tests++; if (mem_rd !== 1'b0) begin fails++;
            $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        tests++; if (mem_addr !== 32'h0) begin fails++;
            $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
        reset = 1'b0;
        tick();
    endtask

    // Ends in cycle W+1 (first cycle with ack low after the final strobe).
    task automatic test_single();
        lat_rand = 1'b0; lat_fixed = 1;
        clear_mon(32'h0010_0C00);
        track_base = 32'h0010_0000; audio_sector = 22'd3; audio_req = 1'b1;
        tick();
        tests++; if (audio_ack !== 1'b1) begin fails++;
            $display("FAIL single_ack_n1: got %b want 1", audio_ack); end
        tests++; if (audio_download !== 1'b1) begin fails++;
            $display("FAIL single_dl_n1: got %b want 1", audio_download); end
        tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0010_0C00) begin fails++;
            $display("FAIL single_first_rd: got rd=%b addr=%h want rd=1 addr=00100c00",
                     mem_rd, mem_addr); end
        audio_req = 1'b0;
        wait_words("single", 512, 3000);
        tests++; if (audio_ack !== 1'b1) begin fails++;
            $display("FAIL single_ack_last: got %b want 1", audio_ack); end
        tick();
        tests++; if (audio_ack !== 1'b0 || audio_download !== 1'b0) begin fails++;
            $display("FAIL single_end: got ack=%b dl=%b want 0 0", audio_ack, audio_download); end
        tests++; if (wr_cnt !== 512) begin fails++;
            $display("FAIL single_count: got %0d want 512", wr_cnt); end
        tests++; if (last_addr !== 32'h0010_0FFE) begin fails++;
            $display("FAIL single_last_addr: got %h want 00100ffe", last_addr); end
        tests++; if (data_err !== 0 || addr_err !== 0) begin fails++;
            $display("FAIL single_order: got data_err=%0d addr_err=%0d want 0 0",
                     data_err, addr_err); end
    endtask

    task automatic test_back_to_back();
        int low_cnt;
        int n;
        low_cnt = (audio_download === 1'b0) ? 1 : 0;
        clear_mon(32'h0010_1000);
        audio_sector = 22'd4; audio_req = 1'b1;
        n = 0;
        while (audio_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (audio_ack !== 1'b1 && audio_download === 1'b0) low_cnt++;
        end
        tests++; if (low_cnt < 2) begin fails++;
            $display("FAIL b2b_gap: got %0d low cycles want >=2", low_cnt); end
        tests++; if (audio_ack !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 32'h0010_1000) begin
            fails++;
            $display("FAIL b2b_start: got ack=%b rd=%b addr=%h want 1 1 00101000",
                     audio_ack, mem_rd, mem_addr); end
        audio_req = 1'b0;
        wait_words("b2b", 512, 3000);
        tick();
        tests++; if (wr_cnt !== 512 || data_err !== 0 || last_addr !== 32'h0010_13FE) begin
            fails++;
            $display("FAIL b2b_data: got cnt=%0d err=%0d last=%h want 512 0 001013fe",
                     wr_cnt, data_err, last_addr); end
    endtask

    task automatic test_variable_latency();
        repeat (3) tick();
        lat_rand = 1'b1;
        multi_rd = 0;
        clear_mon(32'h0020_1C00);
        track_base = 32'h0020_0000; audio_sector = 22'd7; audio_req = 1'b1;
        wait_ack("varlat", 20);
        audio_req = 1'b0;
        wait_words("varlat", 512, 10000);
        tick();
        tests++; if (wr_cnt !== 512) begin fails++;
            $display("FAIL varlat_count: got %0d want 512", wr_cnt); end
        tests++; if (data_err !== 0 || addr_err !== 0) begin fails++;
            $display("FAIL varlat_order: got data_err=%0d addr_err=%0d want 0 0",
                     data_err, addr_err); end
        tests++; if (multi_rd !== 0) begin fails++;
            $display("FAIL varlat_outstanding: got %0d overlaps want 0", multi_rd); end
        tests++; if (last_addr !== 32'h0020_1FFE) begin fails++;
            $display("FAIL varlat_last_addr: got %h want 00201ffe", last_addr); end
        lat_rand = 1'b0;
    endtask

    task automatic test_abort_wait();
        int n;
        int rdy_at_abort;
        repeat (3) tick();
        lat_fixed = 6;
        clear_mon(32'h0010_0C00);
        track_base = 32'h0010_0000; audio_sector = 22'd3; audio_req = 1'b1;
        wait_ack("abort_start", 20);
        audio_req = 1'b0;
        n = 0;
        while (rd_cnt < 101 && n < 2000) begin tick(); n++; end
        tests++; if (rd_cnt != 101) begin fails++;
            $display("FAIL abort_reach: got %0d reads want 101", rd_cnt); end
        tick();                 // now in WAIT for word 100
        abort = 1'b1;
        rdy_at_abort = rdy_cnt;
        tick();
        tests++; if (audio_ack !== 1'b0 || audio_download !== 1'b0) begin fails++;
            $display("FAIL abort_drop: got ack=%b dl=%b want 0 0", audio_ack, audio_download); end
        tests++; if (wr_cnt !== 100) begin fails++;
            $display("FAIL abort_no_wr: got %0d words want 100", wr_cnt); end
        abort = 1'b0;
        lat_fixed = 1;
        // Request immediately; it must wait until the late response is drained.
        clear_mon(32'h0010_1400);
        audio_sector = 22'd5; audio_req = 1'b1;
        wait_ack("abort_restart", 30);
        tests++; if (rdy_cnt !== rdy_at_abort + 1) begin fails++;
            $display("FAIL abort_drain: got %0d responses before ack want %0d",
                     rdy_cnt - rdy_at_abort, 1); end
        tests++; if (wr_cnt !== 0 || mem_addr !== 32'h0010_1400) begin fails++;
            $display("FAIL abort_restart_addr: got wr=%0d addr=%h want 0 00101400",
                     wr_cnt, mem_addr); end
        audio_req = 1'b0;
        wait_words("abort_restart", 512, 3000);
        tick();
        tests++; if (wr_cnt !== 512 || data_err !== 0) begin fails++;
            $display("FAIL abort_restart_data: got cnt=%0d err=%0d want 512 0",
                     wr_cnt, data_err); end
    endtask

    task automatic test_seek_abort_wrap();
        int acks;
        repeat (3) tick();
        acks = 0;
        track_base = 32'h0010_0000; audio_sector = 22'd2;
        audio_seek = 1'b1; abort = 1'b1;
        tick();
        audio_seek = 1'b0; abort = 1'b0;
        repeat (3) begin
            if (audio_ack === 1'b1) acks++;
            tick();
        end
        tests++; if (acks !== 0) begin fails++;
            $display("FAIL collide_no_ack: got %0d ack cycles want 0", acks); end
        clear_mon(32'h0000_0000);
        track_base = 32'hFFFF_FC00; audio_sector = 22'd1; audio_seek = 1'b1;
        wait_ack("wrap", 20);
        tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_0000) begin fails++;
            $display("FAIL wrap_first_addr: got rd=%b addr=%h want 1 00000000",
                     mem_rd, mem_addr); end
        audio_seek = 1'b0;
        wait_words("wrap", 512, 3000);
        tick();
        tests++; if (wr_cnt !== 512 || data_err !== 0 || last_addr !== 32'h0000_03FE) begin
            fails++;
            $display("FAIL wrap_data: got cnt=%0d err=%0d last=%h want 512 0 000003fe",
                     wr_cnt, data_err, last_addr); end
    endtask

    task automatic test_reset_mid();
        int n;
        int highs;
        repeat (3) tick();
        lat_fixed = 3;
        clear_mon(32'h0010_0C00);
        track_base = 32'h0010_0000; audio_sector = 22'd3; audio_req = 1'b1;
        wait_ack("rst_mid_start", 20);
        audio_req = 1'b0;
        n = 0;
        while (rd_cnt < 11 && n < 500) begin tick(); n++; end
        tick();                 // WAIT for word 10
        reset = 1'b1;
        tick();
        tests++; if (audio_ack !== 1'b0 || audio_download !== 1'b0 || audio_data_wr !== 1'b0)
        begin
            fails++;
            $display("FAIL rst_mid_ctl: got ack=%b dl=%b wr=%b want 0 0 0",
                     audio_ack, audio_download, audio_data_wr); end
        tests++; if (mem_rd !== 1'b0 || mem_addr !== 32'h0 || audio_data !== 16'h0) begin
            fails++;
            $display("FAIL rst_mid_data: got rd=%b addr=%h data=%h want 0 00000000 0000",
                     mem_rd, mem_addr, audio_data); end
        reset = 1'b0;
        highs = 0;
        repeat (10) begin
            tick();
            if (audio_ack === 1'b1 || mem_rd === 1'b1) highs++;
        end
        tests++; if (wr_cnt !== 10 || highs !== 0) begin fails++;
            $display("FAIL rst_mid_stray: got wr=%0d active=%0d want 10 0", wr_cnt, highs); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_variable_latency();
        test_abort_wait();
        test_seek_abort_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msu_audio_sector_feeder.md
# msu_audio_sector_feeder

Responder side of the MSU-1 audio sector interface. It services sector requests and seeks from the MSU audio player. For each request it fetches the 1024-byte sector from backing memory as 512 sequential 16-bit reads, then streams the words out on the download/data-write strobes, holding ack for the whole transfer. It sits between the MSU-1 audio player and the SDRAM/DDR arbiter port that holds the loaded PCM track.

## Interface
Parameters:
- none; all widths are fixed by the sector protocol.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- track_base  in  32  byte address of the PCM file in memory; sampled when a request is accepted.
- abort  in  1  level; cancels any transfer in progress (driven from track_processing).
- audio_req  in  1  level; fetch the next sector.
- audio_seek  in  1  level; fetch a sector out of sequence. Treated identically to audio_req.
- audio_sector  in  22  sector index; sampled when a request is accepted.
- audio_ack  out  1  high for the entire transfer of one sector.
- audio_download  out  1  high for the entire transfer; also frames the player's word counter.
- audio_data_wr  out  1  one-cycle strobe per 16-bit word.
- audio_data  out  16  word data; valid when audio_data_wr is high.
- mem_rd  out  1  one-cycle read strobe.
- mem_addr  out  32  byte address; valid with mem_rd.
- mem_ready  in  1  one-cycle strobe; mem_dout is valid.
- mem_dout  in  16  read data.

## Operation
States: IDLE, READ, WAIT, WRITE, DONE, DRAIN.

- **IDLE**
  - ack=0, download=0.
  - If (audio_req | audio_seek) & ~abort:
    - latch sector and track_base;
    - clear word counter wcnt (9 bits);
    - set ack=1 and download=1;
    - go to READ.
- **READ**
  - Pulse mem_rd with mem_addr = base + {sector,10'b0} + {wcnt,1'b0}.
  - All arithmetic is 32-bit modulo (wraps).
  - Go to WAIT.
- **WAIT**
  - On mem_ready: register mem_dout into audio_data, then go to WRITE.
- **WRITE**
  - Pulse audio_data_wr.
  - If wcnt == 511, go to DONE.
  - Otherwise increment wcnt and go to READ.
- **DONE**
  - ack=0, download=0.
  - Go to IDLE.
  - DONE → IDLE guarantees download stays low for at least 2 cycles between sectors; the player relies on this to clear its counter.
- **Abort**, in any non-IDLE state:
  - ack, download and audio_data_wr go to 0 on the next cycle.
  - If a read is outstanding (state WAIT, or READ issuing this cycle), go to DRAIN.
  - Otherwise go to IDLE.
- **DRAIN**
  - Wait for mem_ready, discard the data, then go to IDLE.
  - Requests are not accepted until the block is back in IDLE.

Request and handshake rules:
- Requests are sampled only in IDLE.
- audio_req and audio_seek arriving during a transfer are not latched. The player holds them until it sees ack, then drops them.
- abort wins over a simultaneous request in IDLE: no transfer starts.
- Exactly 512 audio_data_wr pulses occur per non-aborted transfer, in increasing address order (low word first).
- mem_rd never has more than one read outstanding.

Reset:
- All outputs are 0: ack, download, audio_data_wr, audio_data, mem_rd, mem_addr.
- State returns to IDLE.
- A mem_ready arriving after a reset taken mid-read is ignored in IDLE.

## Timing
- Request high in cycle N (state IDLE):
  - ack and download are high from cycle N+1;
  - the first mem_rd is in cycle N+1 (READ entered at N+1).
- Per word:
  - mem_rd in cycle R; mem_ready in cycle R+L, with L ≥ 1;
  - audio_data_wr in cycle R+L+1;
  - the next mem_rd is in cycle R+L+2.
  - Minimum spacing is therefore 3 cycles per word when L = 1.
- After the last audio_data_wr in cycle W, ack and download fall in cycle W+1.
- Earliest next accept is cycle W+2.
- audio_data holds its value until the next mem_ready is captured.

## Test plan
- **Single request**
  - Stimulus: track_base=0x0010_0000, sector=3, zero-wait memory returning word = address[16:1].
  - Required: ack high from N+1; 512 data_wr pulses; first mem_addr=0x0010_0C00, last mem_addr=0x0010_0FFE; ack and download low one cycle after the final strobe.
- **Back-to-back**
  - Stimulus: req re-asserted immediately after ack falls, sector=4.
  - Required: download is low for ≥2 cycles; the second transfer starts at address 0x0010_1000.
- **Variable latency**
  - Stimulus: mem_ready delayed 0–7 random cycles.
  - Required: data order and count are unchanged; never more than one read outstanding.
- **Abort mid-WAIT**
  - Stimulus: abort at word 100 while in WAIT.
  - Required: ack and download drop next cycle; no further data_wr; the late mem_ready is swallowed; a new req after that is accepted normally.
- **Seek/abort collision and address wrap**
  - Stimulus: seek and abort together in IDLE; then seek with base=0xFFFF_FC00, sector=1.
  - Required: no ack for the colliding seek; the second seek's first address is 0x0000_0000 (wraps).
- **Reset mid-transfer**
  - Stimulus: reset at word 10, with a stray mem_ready afterwards.
  - Required: all outputs are 0 the next cycle; the stray mem_ready is ignored; no data_wr is produced.
